// File: rtl/uart_autobaud_if.sv
// uart_autobaud_if: control, serial line and divisor/lock status of the autobaud detector.
interface uart_autobaud_if #(parameter int DIV_WIDTH = 16);
   logic                 clken;
   logic                 rxd;
   logic                 relock;
   logic                 baud_x16_strobe;
   logic [DIV_WIDTH-1:0] divisor;
   logic                 locked;
   logic                 lock_error;
   modport master (output clken, rxd, relock, input baud_x16_strobe, divisor, locked, lock_error);
   modport slave (input clken, rxd, relock, output baud_x16_strobe, divisor, locked, lock_error);
endinterface

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures a 0x55 sync byte to derive a x16 baud divisor and generates the strobe.
// Optional UART_AUTOBAUD_GLITCH_FILTER_EN: 3-sample majority on the synchronized line.
module uart_autobaud #(
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 26,
   parameter int MIN_DIV     = 2
) (
   input logic clk,
   input logic rst,
   uart_autobaud_if.slave bus
);
   localparam int MW = DIV_WIDTH + 7;
   typedef enum logic [1:0] {HUNT = 2'd0, MEASURE = 2'd1, STOP = 2'd2, LOCKED = 2'd3} state_t;
   state_t               state, state_n;
   logic [1:0]           sync;
   logic                 line, line_q, fall, rise, sat, load;
   logic [MW-1:0]        meas_cnt, meas_n;
   logic [1:0]           edge_cnt, edge_n;
   logic [DIV_WIDTH-1:0] cand, cand_n, cand_c, div_q, div_n, cnt, cnt_n;
   logic                 locked_q, locked_n, err_q, err_n, strobe_q, strobe_n;
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
   logic [1:0] hist;
   assign line = (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
   always_ff @(posedge clk or posedge rst)
      if (rst) hist <= 2'b11;
      else if (bus.clken) hist <= {hist[0], sync[1]};
`else
   assign line = sync[1];
`endif
   assign fall = line_q & ~line;
   assign rise = ~line_q & line;
   assign sat = &meas_cnt;
   // (meas_cnt + 64) >> 7 without a wider adder: bit 6 is the rounding carry
   assign cand_c = meas_cnt[MW-1:7] + DIV_WIDTH'(meas_cnt[6]);
   assign bus.divisor = div_q;
   assign bus.locked = locked_q;
   assign bus.lock_error = err_q;
   assign bus.baud_x16_strobe = strobe_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= HUNT;
         sync     <= 2'b11;
         line_q   <= 1'b1;
         meas_cnt <= '0;
         edge_cnt <= '0;
         cand     <= '0;
         div_q    <= DIV_WIDTH'(DEFAULT_DIV);
         cnt      <= DIV_WIDTH'(DEFAULT_DIV - 1);
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         strobe_q <= 1'b0;
      end else if (bus.clken) begin
         state    <= state_n;
         sync     <= {sync[0], bus.rxd};
         line_q   <= line;
         meas_cnt <= meas_n;
         edge_cnt <= edge_n;
         cand     <= cand_n;
         div_q    <= div_n;
         cnt      <= cnt_n;
         locked_q <= locked_n;
         err_q    <= err_n;
         strobe_q <= strobe_n;
      end
   always_comb begin
      state_n  = state;
      meas_n   = meas_cnt;
      edge_n   = edge_cnt;
      cand_n   = cand;
      div_n    = div_q;
      locked_n = locked_q;
      err_n    = 1'b0;
      load     = 1'b0;
      case (state)
         HUNT: if (fall) begin
            state_n = MEASURE;
            meas_n  = MW'(1);
            edge_n  = '0;
         end
         MEASURE: begin
            meas_n = sat ? meas_cnt : meas_cnt + MW'(1);
            if (bus.relock) state_n = HUNT;
            else if (sat) begin
               err_n   = 1'b1;
               state_n = HUNT;
            end else if (fall) begin
               edge_n = edge_cnt + 2'd1;
               if (edge_cnt == 2'd3) begin
                  cand_n  = cand_c;
                  err_n   = cand_c < DIV_WIDTH'(MIN_DIV);
                  state_n = err_n ? HUNT : STOP;
               end
            end
         end
         STOP: if (bus.relock) state_n = HUNT;
         else if (rise) begin
            div_n    = cand;
            locked_n = 1'b1;
            load     = 1'b1;
            state_n  = LOCKED;
         end
         LOCKED: if (bus.relock) begin
            state_n  = HUNT;
            locked_n = 1'b0;
         end
      endcase
      // a divisor update restarts the period without emitting a strobe
      cnt_n    = load ? cand - DIV_WIDTH'(1) : (cnt == '0 ? div_q - DIV_WIDTH'(1) : cnt - DIV_WIDTH'(1));
      strobe_n = !load && cnt == '0;
   end
endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: directed checks of lock, reject, saturation, relock, clken hold, reset and glitch behaviour.
module tb_uart_autobaud;
   logic clk, rst;
   int   n_tests = 0, n_fail = 0, err_cnt = 0, err8_cnt = 0;
   int   e0, lat, p;
   uart_autobaud_if #(.DIV_WIDTH(16)) u ();
   uart_autobaud_if #(.DIV_WIDTH(8)) u8 ();
   uart_autobaud #(.DIV_WIDTH(16), .DEFAULT_DIV(26), .MIN_DIV(2)) dut (.clk(clk), .rst(rst), .bus(u));
   uart_autobaud #(.DIV_WIDTH(8), .DEFAULT_DIV(26), .MIN_DIV(2)) dut8 (.clk(clk), .rst(rst), .bus(u8));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (u.lock_error) err_cnt <= err_cnt + 1;
      if (u8.lock_error) err8_cnt <= err8_cnt + 1;
   end
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic rst_pulse();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(5);
   endtask
   task automatic send_sync(input int n);
      logic [8:0] fr;
      fr = {8'h55, 1'b0};
      for (int i = 0; i < 9; i++) begin
         u.rxd = fr[i];
         tick(n);
      end
   endtask
   task automatic period(output int per);
      int k;
      k = 0;
      while (!u.baud_x16_strobe && k < 200) begin
         tick(1);
         k++;
      end
      tick(1);
      per = 1;
      while (!u.baud_x16_strobe && per < 200) begin
         tick(1);
         per++;
      end
   endtask
   task automatic wait_lock(output int l);
      l = 0;
      while (!u.locked && l < 10) begin
         tick(1);
         l++;
      end
   endtask
   initial begin
      rst = 1'b1;
      u.clken = 1'b1; u.rxd = 1'b1; u.relock = 1'b0;
      u8.clken = 1'b1; u8.rxd = 1'b1; u8.relock = 1'b0;
      tick(3);
      chk("rst_divisor", u.divisor, 26);
      chk("rst_locked", u.locked, 0);
      chk("rst_lock_error", u.lock_error, 0);
      chk("rst_strobe", u.baud_x16_strobe, 0);
      chk("rst_state", 32'(dut.state), 0);
      chk("rst_cnt", dut.cnt, 25);
      rst = 1'b0;
      tick(5);
      period(p);
      chk("default_period", p, 26);
      e0 = err_cnt;
      send_sync(416);
      u.rxd = 1'b1;
      wait_lock(lat);
      chk("lock416_latency_le3", 32'(lat <= 3), 1);
      chk("lock416_locked", u.locked, 1);
      chk("lock416_divisor", u.divisor, 26);
      chk("lock416_no_error", err_cnt - e0, 0);
      tick(416);
      chk("lock416_state", 32'(dut.state), 3);
      period(p);
      chk("lock416_period", p, 26);
      u.relock = 1'b1;
      tick(1);
      u.relock = 1'b0;
      chk("relock_locked_drop", u.locked, 0);
      chk("relock_divisor_kept", u.divisor, 26);
      chk("relock_state", 32'(dut.state), 0);
      tick(5);
      send_sync(208);
      u.rxd = 1'b1;
      wait_lock(lat);
      chk("lock208_locked", u.locked, 1);
      chk("lock208_divisor", u.divisor, 13);
      tick(208);
      period(p);
      chk("lock208_period", p, 13);
      u.clken = 1'b0; u.relock = 1'b1; u.rxd = 1'b0;
      tick(10);
      chk("clken0_locked", u.locked, 1);
      chk("clken0_divisor", u.divisor, 13);
      u.relock = 1'b0; u.rxd = 1'b1;
      tick(5);
      u.clken = 1'b1;
      tick(5);
      chk("clken0_state", 32'(dut.state), 3);
      rst_pulse();
      e0 = err_cnt;
      send_sync(16);
      u.rxd = 1'b1;
      tick(20);
      chk("short_error_pulses", err_cnt - e0, 1);
      chk("short_state", 32'(dut.state), 0);
      chk("short_locked", u.locked, 0);
      chk("short_divisor", u.divisor, 26);
      e0 = err8_cnt;
      u8.rxd = 1'b0;
      tick(40000);
      chk("sat8_error_pulses", err8_cnt - e0, 1);
      chk("sat8_state", 32'(dut8.state), 0);
      chk("sat8_locked", u8.locked, 0);
      u8.rxd = 1'b1;
      rst_pulse();
      u.rxd = 1'b0;
      tick(1);
      u.rxd = 1'b1;
      tick(5);
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
      chk("glitch_state", 32'(dut.state), 0);
`else
      chk("glitch_state", 32'(dut.state), 1);
`endif
      rst_pulse();
      u.rxd = 1'b0; tick(416);
      u.rxd = 1'b1; tick(416);
      u.rxd = 1'b0; tick(100);
      rst = 1'b1;
      tick(2);
      chk("midrst_divisor", u.divisor, 26);
      chk("midrst_locked", u.locked, 0);
      chk("midrst_lock_error", u.lock_error, 0);
      chk("midrst_strobe", u.baud_x16_strobe, 0);
      chk("midrst_state", 32'(dut.state), 0);
      chk("midrst_meas_cnt", dut.meas_cnt, 0);
      chk("midrst_edge_cnt", dut.edge_cnt, 0);
      chk("midrst_cnt", dut.cnt, 25);
      rst = 1'b0;
      tick(316);
      for (int i = 2; i < 8; i++) begin
         u.rxd = (i % 2 == 0);
         tick(416);
      end
      u.rxd = 1'b1;
      tick(1248);
      chk("midrst_no_lock", u.locked, 0);
      chk("midrst_divisor_after", u.divisor, 26);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
